// File: rtl/snake_dir_ctrl_pkg.sv
// Shared encodings for the snake direction controller.
//   dir_e   : movement directions, UP=0 RIGHT=1 DOWN=2 LEFT=3
//   state_e : game-control states, IDLE=0 RUN=1 PAUSE=2 OVER=3
//   is_reversal() : true when two directions point opposite ways
// The body and position logic use the same direction encoding.
package snake_dir_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Opposite directions differ only in bit 1 (UP/DOWN, RIGHT/LEFT).
    function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_dir_fifo.sv
// Turn queue: 2-bit wide, QDEPTH deep FIFO of pending directions.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : enqueue din at the tail
//   pop           : dequeue the head (ignored when empty)
//   flush         : empty the queue (wins over push/pop)
//   head, tail    : oldest and newest entries (undefined when count==0)
//   count         : number of stored entries, 0..QDEPTH
// A push and a pop in the same cycle are both honoured; a push into a
// full queue is honoured only when the same-cycle pop frees a slot.
module snake_dir_ctrl_dir_fifo #(
    parameter  int QDEPTH = 2,
    localparam int CW     = $clog2(QDEPTH + 1),
    localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [1:0]    din,
    output logic [1:0]    head,
    output logic [1:0]    tail,
    output logic [CW-1:0] count
);

    logic [1:0]    mem_q [QDEPTH];
    logic [1:0]    mem_d [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(QDEPTH - 1) : p - 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(QDEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign tail  = mem_q[ptr_dec(wr_ptr_q)];
    assign count = count_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: turns debounced key pulses into the movement
// direction and a one-cycle step strobe per move tick, buffering up to
// QDEPTH turns between ticks and owning the IDLE/RUN/PAUSE/OVER state.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   key_*_v         : 1-cycle debounced button pulses (up/right/down/left/pause)
//   tick            : 1-cycle move-tick strobe
//   game_over       : collision level from the body logic
//   dir             : current direction (UP=0 RIGHT=1 DOWN=2 LEFT=3)
//   step            : 1-cycle strobe, the cycle after an accepted tick
//   state           : IDLE=0 RUN=1 PAUSE=2 OVER=3 (also the FSM debug view)
//   q_count         : queued turns
//   drop            : 1-cycle pulse, a direction press was rejected
// All outputs are registered.
module snake_dir_ctrl
    import snake_dir_ctrl_pkg::*;
#(
    parameter  int         QDEPTH   = 2,
    parameter  logic [1:0] INIT_DIR = 2'd1,
    localparam int         CW       = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_up_v,
    input  logic          key_right_v,
    input  logic          key_down_v,
    input  logic          key_left_v,
    input  logic          key_pause_v,
    input  logic          tick,
    input  logic          game_over,
    output logic [1:0]    dir,
    output logic          step,
    output logic [1:0]    state,
    output logic [CW-1:0] q_count,
    output logic          drop
);

    state_e        state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic          step_q, step_d;
    logic          drop_q, drop_d;

    logic [3:0]    keys;
    logic [1:0]    press_dir;
    logic          press_valid;
    logic          press_multi;

    logic [1:0]    fifo_head;
    logic [1:0]    fifo_tail;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;
    logic          fifo_flush;

    logic          press_live;
    logic          tick_run;
    logic          pop_eff;
    logic [CW-1:0] count_after;
    logic [1:0]    last_dir;
    logic          reject;

    // One-hot press encoder: only a single direction pulse is a press.
    always_comb begin
        keys        = {key_left_v, key_down_v, key_right_v, key_up_v};
        press_valid = 1'b1;
        press_dir   = DIR_UP;
        unique case (keys)
            4'b0001: press_dir = DIR_UP;
            4'b0010: press_dir = DIR_RIGHT;
            4'b0100: press_dir = DIR_DOWN;
            4'b1000: press_dir = DIR_LEFT;
            default: press_valid = 1'b0;
        endcase
        press_multi = (keys != 4'b0000) && !press_valid;
    end

    // Qualification: the pop of a tick happens first, then the press is
    // compared with the newest direction that will exist after that pop.
    always_comb begin
        press_live  = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !game_over);
        tick_run    = (state_q == ST_RUN) && tick && !key_pause_v && !game_over;
        pop_eff     = tick_run && (fifo_count != '0);
        count_after = fifo_count - CW'(pop_eff);
        if (count_after != '0) begin
            last_dir = fifo_tail;
        end else if (pop_eff) begin
            last_dir = fifo_head;
        end else begin
            last_dir = dir_q;
        end
        reject      = (press_dir == last_dir) || is_reversal(press_dir, last_dir) ||
                      (count_after == CW'(QDEPTH));
        fifo_push   = press_live && press_valid && !reject;
        drop_d      = press_live && (press_multi || (press_valid && reject));
        step_d      = tick_run;
    end

    // Game-control FSM plus direction update.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        fifo_flush = 1'b0;
        if (pop_eff) begin
            dir_d = fifo_head;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (fifo_push) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_d    = ST_OVER;
                    fifo_flush = 1'b1;
                end else if (key_pause_v) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_d    = ST_OVER;
                    fifo_flush = 1'b1;
                end else if (key_pause_v) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (key_pause_v) begin
                    state_d    = ST_IDLE;
                    dir_d      = INIT_DIR;
                    fifo_flush = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= INIT_DIR;
            step_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            drop_q  <= drop_d;
        end
    end

    snake_dir_ctrl_dir_fifo #(
        .QDEPTH (QDEPTH)
    ) u_dir_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (tick_run),
        .flush (fifo_flush),
        .din   (press_dir),
        .head  (fifo_head),
        .tail  (fifo_tail),
        .count (fifo_count)
    );

    assign dir     = dir_q;
    assign step    = step_q;
    assign state   = state_q;
    assign q_count = fifo_count;
    assign drop    = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;

    localparam int QDEPTH = 2;
    localparam int CW     = $clog2(QDEPTH + 1);
    localparam int INIT   = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_up_v = 1'b0, key_right_v = 1'b0, key_down_v = 1'b0, key_left_v = 1'b0;
    logic          key_pause_v = 1'b0, tick = 1'b0, game_over = 1'b0;
    logic [1:0]    dir;
    logic          step;
    logic [1:0]    state;
    logic [CW-1:0] q_count;
    logic          drop;

    snake_dir_ctrl #(.QDEPTH(QDEPTH), .INIT_DIR(2'd1)) dut (
        .clk(clk), .rst(rst),
        .key_up_v(key_up_v), .key_right_v(key_right_v),
        .key_down_v(key_down_v), .key_left_v(key_left_v),
        .key_pause_v(key_pause_v), .tick(tick), .game_over(game_over),
        .dir(dir), .step(step), .state(state), .q_count(q_count), .drop(drop)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural model: state as small integers, pending turns as a queue
    int         m_dir   = INIT;
    int         m_state = 0;
    int         m_step  = 0;
    int         m_drop  = 0;
    logic [1:0] m_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // pin both the DUT and the model to a hand-computed value
    task automatic pin(input string name, input int act, input int model_v, input int lit);
        check({name, "_dut"}, act, lit);
        check({name, "_model"}, model_v, lit);
    endtask

    function automatic bit legal(input int p);
        int last;
        last = (m_q.size() > 0) ? int'(m_q[$]) : m_dir;
        return (p != last) && (((p + 2) % 4) != last) && (m_q.size() < QDEPTH);
    endfunction

    task automatic model_step(input logic r, input logic [3:0] k, input logic pz,
                              input logic tk, input logic go);
        int n;
        int p;
        n = $countones(k);
        p = 0;
        for (int i = 0; i < 4; i++) if (k[i]) p = i;
        m_step = 0;
        m_drop = 0;
        if (r) begin
            m_dir = INIT; m_state = 0; m_q.delete();
            return;
        end
        case (m_state)
            0: begin
                if (n > 1) m_drop = 1;
                else if (n == 1) begin
                    if (legal(p)) begin m_q.push_back(2'(p)); m_state = 1; end
                    else m_drop = 1;
                end
            end
            1: begin
                if (go) begin
                    m_state = 3; m_q.delete();
                end else begin
                    if (tk && !pz) begin
                        m_step = 1;
                        if (m_q.size() > 0) m_dir = int'(m_q.pop_front());
                    end
                    if (n > 1) m_drop = 1;
                    else if (n == 1) begin
                        if (legal(p)) m_q.push_back(2'(p));
                        else m_drop = 1;
                    end
                    if (pz) m_state = 2;
                end
            end
            2: begin
                if (go) begin m_state = 3; m_q.delete(); end
                else if (pz) m_state = 1;
            end
            default: begin
                if (pz) begin m_state = 0; m_dir = INIT; m_q.delete(); end
            end
        endcase
    endtask

    // driver: inputs change at the negedge, both DUT and model advance on posedge
    task automatic apply(input logic [3:0] k, input logic pz, input logic tk,
                         input logic go, input logic r);
        {key_left_v, key_down_v, key_right_v, key_up_v} = k;
        key_pause_v = pz;
        tick        = tk;
        game_over   = go;
        rst         = r;
        @(posedge clk);
        model_step(r, k, pz, tk, go);
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        apply(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // compare process: every cycle, all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("dir",     int'(dir),     m_dir);
            check("step",    int'(step),    m_step);
            check("state",   int'(state),   m_state);
            check("q_count", int'(q_count), m_q.size());
            check("drop",    int'(drop),    m_drop);
        end
    end

    localparam logic [3:0] K_UP = 4'b0001, K_RT = 4'b0010, K_DN = 4'b0100, K_LT = 4'b1000;
    localparam logic [3:0] K_NO = 4'b0000;

    initial begin
        logic [3:0] k;
        int r;
        // reset values
        apply(K_NO, 0, 0, 0, 1);
        pin("rst_dir", dir, m_dir, 1);
        pin("rst_state", state, m_state, 0);
        pin("rst_qc", q_count, m_q.size(), 0);
        pin("rst_step", step, m_step, 0);
        pin("rst_drop", drop, m_drop, 0);

        // 1: press UP in IDLE, then a tick
        apply(K_UP, 0, 0, 0, 0);
        pin("t1_state", state, m_state, 1);
        pin("t1_qc", q_count, m_q.size(), 1);
        apply(K_NO, 0, 1, 0, 0);
        pin("t1_dir", dir, m_dir, 0);
        pin("t1_step", step, m_step, 1);
        idle_cyc();
        pin("t1_step_off", step, m_step, 0);

        // 2: get to RIGHT, then reversal and repeat are dropped
        apply(K_RT, 0, 0, 0, 0);
        apply(K_NO, 0, 1, 0, 0);
        pin("t2_dir_r", dir, m_dir, 1);
        apply(K_LT, 0, 0, 0, 0);
        pin("t2_drop_rev", drop, m_drop, 1);
        pin("t2_qc", q_count, m_q.size(), 0);
        apply(K_NO, 0, 1, 0, 0);
        pin("t2_dir_hold", dir, m_dir, 1);
        apply(K_RT, 0, 0, 0, 0);
        pin("t2_drop_rep", drop, m_drop, 1);

        // 3: double turn UP, LEFT before the tick
        apply(K_UP, 0, 0, 0, 0);
        apply(K_LT, 0, 0, 0, 0);
        pin("t3_qc", q_count, m_q.size(), 2);
        apply(K_NO, 0, 1, 0, 0);
        pin("t3_dir1", dir, m_dir, 0);
        apply(K_NO, 0, 1, 0, 0);
        pin("t3_dir2", dir, m_dir, 3);

        // 4: back to RIGHT, fill queue, push into the slot freed by a tick
        apply(K_UP, 0, 0, 0, 0);
        apply(K_NO, 0, 1, 0, 0);
        apply(K_RT, 0, 0, 0, 0);
        apply(K_NO, 0, 1, 0, 0);
        pin("t4_dir_r", dir, m_dir, 1);
        apply(K_UP, 0, 0, 0, 0);
        apply(K_LT, 0, 0, 0, 0);
        apply(K_DN, 0, 0, 0, 0);
        pin("t4_drop_full", drop, m_drop, 1);
        apply(K_DN, 0, 1, 0, 0);
        pin("t4_dir", dir, m_dir, 0);
        pin("t4_qc", q_count, m_q.size(), 2);
        pin("t4_drop", drop, m_drop, 0);

        // 5: two keys at once, then pause
        apply(K_UP | K_LT, 0, 0, 0, 0);
        pin("t5_drop_multi", drop, m_drop, 1);
        pin("t5_qc", q_count, m_q.size(), 2);
        apply(K_NO, 1, 0, 0, 0);
        pin("t5_pause", state, m_state, 2);
        for (int i = 0; i < 3; i++) begin
            apply(K_NO, 0, 1, 0, 0);
            pin("t5_nostep", step, m_step, 0);
        end
        pin("t5_dir_held", dir, m_dir, 0);
        apply(K_NO, 1, 0, 0, 0);
        pin("t5_run", state, m_state, 1);
        apply(K_NO, 0, 1, 0, 0);
        pin("t5_step", step, m_step, 1);
        pin("t5_dir", dir, m_dir, 3);

        // 6: game over with a full queue, restart, reset mid-run
        apply(K_RT, 0, 0, 0, 0);
        pin("t6_qc_full", q_count, m_q.size(), 2);
        apply(K_NO, 0, 1, 1, 0);
        pin("t6_over", state, m_state, 3);
        pin("t6_qc", q_count, m_q.size(), 0);
        pin("t6_step", step, m_step, 0);
        apply(K_NO, 0, 1, 0, 0);
        pin("t6_step_late", step, m_step, 0);
        apply(K_NO, 1, 0, 0, 0);
        pin("t6_idle", state, m_state, 0);
        pin("t6_dir", dir, m_dir, 1);
        apply(K_UP, 0, 0, 0, 0);
        apply(K_NO, 0, 1, 1, 1);
        pin("t6_rst_state", state, m_state, 0);
        pin("t6_rst_step", step, m_step, 0);
        pin("t6_rst_dir", dir, m_dir, 1);

        // randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            k = 4'b0000;
            if (r < 30) k[$urandom_range(0, 3)] = 1'b1;
            else if (r < 36) k = 4'($urandom_range(0, 15));
            apply(k,
                  $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 399) < 1);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
